// File: rtl/fifo2_arb_pkg.sv
// Shared definitions for the round-robin arbiter and its 2-entry output queue:
// width helpers, entry field layout and the queue occupancy states.
package fifo2_arb_pkg;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_TWO   = 2'd2
    } qstate_e;

    localparam int DATA_LSB = 0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int srcWidth(input int nreq);
        return (nreq < 2) ? 1 : clog2(nreq);
    endfunction

    // Entry layout, LSB first: data, last flag, source index.
    function automatic int entWidth(input int width, input int nreq);
        return width + srcWidth(nreq) + 1;
    endfunction

    function automatic int lastBit(input int width);
        return width;
    endfunction

    function automatic int srcLsb(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/fifo2_entry_buf.sv
// Two-entry FIFO of tagged beats; accepts a push while full when a pop happens
// in the same cycle. Only the occupancy state is reset, never the data.
module fifo2_entry_buf
    import fifo2_arb_pkg::*;
#(
    parameter int entW = 35
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CLR,
    input  logic            ENQ,
    input  logic            DEQ,
    input  logic [entW-1:0] D_IN,
    output logic [entW-1:0] D_OUT,
    output logic            EMPTY_N,
    output logic            FULL_N
);

    qstate_e         r_state;
    logic [entW-1:0] r_data0;
    logic [entW-1:0] r_data1;
    logic            w_doDeq;
    logic            w_doEnq;

    assign w_doDeq = DEQ && !CLR && (r_state != Q_EMPTY);
    assign w_doEnq = ENQ && !CLR && ((r_state != Q_TWO) || w_doDeq);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= Q_EMPTY;
        end else if (CLR) begin
            r_state <= Q_EMPTY;
        end else begin
            case (r_state)
                Q_EMPTY: if (w_doEnq) r_state <= Q_ONE;
                Q_ONE: begin
                    if (w_doEnq && !w_doDeq)
                        r_state <= Q_TWO;
                    else if (w_doDeq && !w_doEnq)
                        r_state <= Q_EMPTY;
                end
                Q_TWO: if (w_doDeq && !w_doEnq) r_state <= Q_ONE;
                default: r_state <= Q_EMPTY;
            endcase
        end
    end

    // r_data0 is always the head; a pop from TWO shifts the tail forward.
    always_ff @(posedge CLK) begin
        case (r_state)
            Q_EMPTY: if (w_doEnq) r_data0 <= D_IN;
            Q_ONE: begin
                if (w_doEnq && w_doDeq)
                    r_data0 <= D_IN;
                else if (w_doEnq)
                    r_data1 <= D_IN;
            end
            Q_TWO: begin
                if (w_doDeq) begin
                    r_data0 <= r_data1;
                    if (w_doEnq) r_data1 <= D_IN;
                end
            end
            default: ;
        endcase
    end

    assign D_OUT   = r_data0;
    assign EMPTY_N = (r_state != Q_EMPTY);
    assign FULL_N  = (r_state != Q_TWO);

endmodule

// File: rtl/fifo2_rr_arbiter.sv
// Round-robin arbiter feeding one shared 2-deep queue; optionally holds the
// grant on a requester until that requester's last beat has been accepted.
module fifo2_rr_arbiter
    import fifo2_arb_pkg::*;
#(
    parameter int width     = 32,
    parameter int nreq      = 4,
    parameter int lock_msgs = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [nreq*width-1:0]       REQ_DATA,
    input  logic [nreq-1:0]             REQ_VALID,
    input  logic [nreq-1:0]             REQ_LAST,
    output logic [nreq-1:0]             REQ_READY,
    output logic [nreq-1:0]             GRANT,
    output logic [width-1:0]            D_OUT,
    output logic [srcWidth(nreq)-1:0]   SRC_OUT,
    output logic                        LAST_OUT,
    output logic                        EMPTY_N,
    input  logic                        DEQ,
    input  logic                        CLR,
    output logic                        BUSY
);

    localparam int SRCW     = srcWidth(nreq);
    localparam int ENT_W    = entWidth(width, nreq);
    localparam int LAST_BIT = lastBit(width);
    localparam int SRC_LSB  = srcLsb(width);

    logic [SRCW-1:0]  r_rrPtr;
    logic [SRCW-1:0]  r_lockedSrc;
    logic             r_lock;
    logic [SRCW-1:0]  w_winner;
    logic             w_found;
    int               w_idx;
    logic             w_space;
    logic             w_accept;
    logic             w_fullN;
    logic             w_emptyN;
    logic [ENT_W-1:0] w_enqEntry;
    logic [ENT_W-1:0] w_headEntry;

    // Descending scan so the requester closest to r_rrPtr is written last and wins.
    always_comb begin
        w_winner = r_lockedSrc;
        w_found  = r_lock;
        w_idx    = 0;
        if (!r_lock) begin
            for (int k = nreq - 1; k >= 0; k--) begin
                w_idx = (int'(r_rrPtr) + k) % nreq;
                if (REQ_VALID[w_idx]) begin
                    w_winner = SRCW'(w_idx);
                    w_found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        GRANT = '0;
        if (w_found && !RST) GRANT[w_winner] = 1'b1;
    end

    assign w_space    = w_fullN | DEQ;
    assign REQ_READY  = GRANT & {nreq{w_space & ~CLR}};
    assign w_accept   = |(REQ_VALID & REQ_READY);
    assign w_enqEntry = {w_winner, REQ_LAST[w_winner], REQ_DATA[int'(w_winner)*width +: width]};

    fifo2_entry_buf #(
        .entW (ENT_W)
    ) u_buf (
        .CLK     (CLK),
        .RST     (RST),
        .CLR     (CLR),
        .ENQ     (w_accept),
        .DEQ     (DEQ),
        .D_IN    (w_enqEntry),
        .D_OUT   (w_headEntry),
        .EMPTY_N (w_emptyN),
        .FULL_N  (w_fullN)
    );

    // A non-last beat pins the grant; the rotation pointer only moves on message end.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rrPtr     <= '0;
            r_lock      <= 1'b0;
            r_lockedSrc <= '0;
        end else if (CLR) begin
            r_rrPtr     <= '0;
            r_lock      <= 1'b0;
            r_lockedSrc <= '0;
        end else if (w_accept) begin
            if ((lock_msgs != 0) && !REQ_LAST[w_winner]) begin
                r_lock      <= 1'b1;
                r_lockedSrc <= w_winner;
            end else begin
                r_lock  <= 1'b0;
                r_rrPtr <= (int'(w_winner) == nreq - 1) ? '0 : w_winner + SRCW'(1);
            end
        end
    end

    assign D_OUT    = w_headEntry[DATA_LSB +: width];
    assign LAST_OUT = w_headEntry[LAST_BIT];
    assign SRC_OUT  = w_headEntry[SRC_LSB +: SRCW];
    assign EMPTY_N  = w_emptyN;
    assign BUSY     = r_lock;

endmodule

// File: tb/tb_fifo2_rr_arbiter.sv
// Randomised and directed bench for fifo2_rr_arbiter (4 requesters, 32-bit data,
// message lock on) checked against a queue-based reference model.
module tb_fifo2_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                   CLK;
    logic                   RST;
    logic [NREQ*WIDTH-1:0]  REQ_DATA;
    logic [NREQ-1:0]        REQ_VALID;
    logic [NREQ-1:0]        REQ_LAST;
    logic [NREQ-1:0]        REQ_READY;
    logic [NREQ-1:0]        GRANT;
    logic [WIDTH-1:0]       D_OUT;
    logic [1:0]             SRC_OUT;
    logic                   LAST_OUT;
    logic                   EMPTY_N;
    logic                   DEQ;
    logic                   CLR;
    logic                   BUSY;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          src;
        logic        last;
        logic [31:0] data;
    } entry_t;

    entry_t mQ[$];
    int     mRr;
    int     mLockedSrc;
    bit     mLock;

    fifo2_rr_arbiter #(
        .width     (WIDTH),
        .nreq      (NREQ),
        .lock_msgs (1)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_DATA  (REQ_DATA),
        .REQ_VALID (REQ_VALID),
        .REQ_LAST  (REQ_LAST),
        .REQ_READY (REQ_READY),
        .GRANT     (GRANT),
        .D_OUT     (D_OUT),
        .SRC_OUT   (SRC_OUT),
        .LAST_OUT  (LAST_OUT),
        .EMPTY_N   (EMPTY_N),
        .DEQ       (DEQ),
        .CLR       (CLR),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] randData();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] withSlice(input logic [127:0] base, input int idx, input logic [31:0] v);
        logic [127:0] r;
        r = base;
        r[idx*32 +: 32] = v;
        return r;
    endfunction

    task automatic modelReset();
        mQ.delete();
        mRr        = 0;
        mLockedSrc = 0;
        mLock      = 0;
    endtask

    // Drives one cycle of inputs at the falling edge, checks the combinational
    // and head outputs against the model, advances the model, then waits for
    // the next falling edge.
    task automatic applyStimulus(input bit clr, input bit deq, input logic [3:0] valid,
                                 input logic [3:0] last, input logic [127:0] data);
        int          win;
        bit          found;
        bit          space;
        logic [3:0]  expGrant;
        logic [3:0]  expReady;
        bit          accept;
        entry_t      e;
        CLR       = clr;
        DEQ       = deq;
        REQ_VALID = valid;
        REQ_LAST  = last;
        REQ_DATA  = data;
        #1;
        found = 0;
        win   = 0;
        if (mLock) begin
            found = 1;
            win   = mLockedSrc;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && valid[(mRr + k) % NREQ]) begin
                    found = 1;
                    win   = (mRr + k) % NREQ;
                end
            end
        end
        expGrant = found ? (4'b0001 << win) : 4'b0000;
        space    = (mQ.size() < 2) || deq;
        expReady = (space && !clr) ? expGrant : 4'b0000;
        accept   = |(valid & expReady);
        checkOutput("grant", GRANT, expGrant);
        checkOutput("ready", REQ_READY, expReady);
        checkOutput("emptyN", EMPTY_N, mQ.size() > 0);
        checkOutput("busy", BUSY, mLock);
        if (mQ.size() > 0) begin
            checkOutput("headData", D_OUT, mQ[0].data);
            checkOutput("headSrc", SRC_OUT, mQ[0].src);
            checkOutput("headLast", LAST_OUT, mQ[0].last);
        end
        if (clr) begin
            modelReset();
        end else begin
            if (deq && mQ.size() > 0) void'(mQ.pop_front());
            if (accept) begin
                e.src  = win;
                e.last = last[win];
                e.data = data[win*32 +: 32];
                mQ.push_back(e);
                if (!last[win]) begin
                    mLock      = 1;
                    mLockedSrc = win;
                end else begin
                    mLock = 0;
                    mRr   = (win + 1) % NREQ;
                end
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        logic [127:0] d;
        RST       = 1'b1;
        CLR       = 1'b0;
        DEQ       = 1'b0;
        REQ_VALID = 4'b1111;
        REQ_LAST  = 4'b1111;
        REQ_DATA  = '0;
        modelReset();

        // Reset state: requests ignored, queue empty.
        #1;
        checkOutput("rstEmptyN", EMPTY_N, 1'b0);
        checkOutput("rstGrant", GRANT, 4'b0000);
        checkOutput("rstReady", REQ_READY, 4'b0000);
        checkOutput("rstBusy", BUSY, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        applyStimulus(0, 0, 4'b0001, 4'b0001, randData());
        checkOutput("firstSrc", SRC_OUT, 2'd0);
        checkOutput("firstEmptyN", EMPTY_N, 1'b1);

        // Fairness: every requester always valid with single-beat messages.
        applyStimulus(1, 0, 4'b0000, 4'b0000, randData());
        for (int k = 0; k < 12; k++) begin
            if (k >= 1) begin
                checkOutput("fairSrc", SRC_OUT, (k - 1) % 4);
                checkOutput("fairNoGap", EMPTY_N, 1'b1);
            end
            applyStimulus(0, 1, 4'b1111, 4'b1111, randData());
        end

        // Locked three-beat message from requester 2 while everyone competes.
        applyStimulus(1, 0, 4'b0000, 4'b0000, randData());
        applyStimulus(0, 1, 4'b0010, 4'b1111, randData());
        d = withSlice(randData(), 2, 32'hA);
        applyStimulus(0, 1, 4'b1111, 4'b1011, d);
        checkOutput("lockDataA", D_OUT, 32'hA);
        checkOutput("lockSrcA", SRC_OUT, 2'd2);
        checkOutput("lockBusyA", BUSY, 1'b1);
        d = withSlice(randData(), 2, 32'hB);
        applyStimulus(0, 1, 4'b1111, 4'b1011, d);
        checkOutput("lockDataB", D_OUT, 32'hB);
        checkOutput("lockSrcB", SRC_OUT, 2'd2);
        checkOutput("lockBusyB", BUSY, 1'b1);
        d = withSlice(randData(), 2, 32'hC);
        applyStimulus(0, 1, 4'b1111, 4'b1111, d);
        checkOutput("lockDataC", D_OUT, 32'hC);
        checkOutput("lockLastC", LAST_OUT, 1'b1);
        checkOutput("lockBusyC", BUSY, 1'b0);
        checkOutput("lockNextGrant", GRANT, 4'b1000);

        // Backpressure: fill to two, then enqueue-with-dequeue while full.
        applyStimulus(1, 0, 4'b0000, 4'b0000, randData());
        applyStimulus(0, 0, 4'b0010, 4'b1111, randData());
        applyStimulus(0, 0, 4'b0010, 4'b1111, randData());
        checkOutput("bpReadyFull", REQ_READY, 4'b0000);
        DEQ = 1'b1;
        #1;
        checkOutput("bpReadyDeq", REQ_READY, 4'b0010);
        applyStimulus(0, 1, 4'b0010, 4'b1111, REQ_DATA);
        DEQ = 1'b0;
        #1;
        checkOutput("bpStillTwo", REQ_READY, 4'b0000);
        applyStimulus(0, 0, 4'b0010, 4'b1111, randData());

        // Locked stall: requester 0 idles mid-message while requester 3 waits.
        applyStimulus(1, 0, 4'b0000, 4'b0000, randData());
        applyStimulus(0, 1, 4'b0001, 4'b0000, randData());
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 4'b1000, 4'b1111, randData());
            checkOutput("stallGrant", GRANT, 4'b0001);
            checkOutput("stallBusy", BUSY, 1'b1);
        end
        checkOutput("stallNoReq3", EMPTY_N, 1'b0);
        applyStimulus(0, 1, 4'b0001, 4'b0001, randData());

        // Flush with two entries queued and the lock held.
        applyStimulus(1, 1, 4'b0000, 4'b0000, randData());
        applyStimulus(0, 0, 4'b0010, 4'b1111, randData());
        applyStimulus(0, 1, 4'b0100, 4'b0000, randData());
        applyStimulus(0, 0, 4'b0100, 4'b0000, randData());
        checkOutput("clrPreBusy", BUSY, 1'b1);
        applyStimulus(1, 0, 4'b1111, 4'b1111, randData());
        checkOutput("clrEmptyN", EMPTY_N, 1'b0);
        checkOutput("clrBusy", BUSY, 1'b0);
        checkOutput("clrGrant", GRANT, 4'b0001);

        // Random traffic with occasional flushes.
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                          4'($urandom), 4'($urandom), randData());
        end

        // Asynchronous reset in the middle of a locked message.
        applyStimulus(1, 0, 4'b0000, 4'b0000, randData());
        applyStimulus(0, 0, 4'b0001, 4'b0000, randData());
        applyStimulus(0, 0, 4'b0001, 4'b0000, randData());
        REQ_VALID = 4'b1111;
        #3;
        RST = 1'b1;
        #1;
        checkOutput("midRstEmptyN", EMPTY_N, 1'b0);
        checkOutput("midRstGrant", GRANT, 4'b0000);
        checkOutput("midRstReady", REQ_READY, 4'b0000);
        checkOutput("midRstBusy", BUSY, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        modelReset();
        applyStimulus(0, 0, 4'b0001, 4'b0001, randData());
        checkOutput("postRstSrc", SRC_OUT, 2'd0);
        checkOutput("postRstEmptyN", EMPTY_N, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
